// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults, bit-period helper and state encodings
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_UART_BPS = 115_200;

  // Serializer line phases; GAP is the sequencer's inter-byte idle.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_BYTE, SEQ_GAP} seq_t;

  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 single-byte serializer with start/done handshake
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BPS_CNT = bps_cnt(DEF_CLK_FREQ, DEF_UART_BPS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       last,
  output logic       txd,
  output logic       done
);

  localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX_SHORT = CNT_W'(BPS_CNT - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             last_q;

  // The last byte's stop bit is one cycle short: the sequencer's first IDLE
  // cycle (line still high) supplies its final cycle, so back-to-back words
  // follow with no extra idle.
  assign done = (state == STOP) && (cnt == (last_q ? CNT_MAX_SHORT : CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= START;
            txd    <= 1'b0;
            shreg  <= data;
            last_q <= last;
            cnt    <= '0;
          end
        end
        START: begin
          if (cnt == CNT_MAX) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (done) begin
            cnt <= '0;
            if (start) begin
              state  <= START;
              txd    <= 1'b0;
              shreg  <= data;
              last_q <= last;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_64.sv
// rtl/uart_tx_64.sv - sends a 64-bit word as eight 8N1 frames, LSB byte first
module uart_tx_64
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int UART_BPS = DEF_UART_BPS,
  parameter int GAP_CYC  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_64,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic        uart_txd,
  output logic        busy,
  output logic        tx_done
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  seq_t             state;
  logic [63:0]      hold;
  logic [2:0]       byte_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             next_byte;
  logic             bt_start;
  logic             bt_last;
  logic             bt_done;
  logic [7:0]       bt_data;

  assign accept    = data_in_valid && data_in_ready;
  assign next_byte = ((state == SEQ_BYTE) && bt_done && (byte_idx != 3'd7) && (GAP_CYC == 0))
                  || ((state == SEQ_GAP) && (gap_cnt == GAP_MAX));
  assign bt_start  = accept || next_byte;
  // Byte 0 goes straight from the input; hold keeps only the bytes still to send.
  assign bt_data   = accept ? data_64[7:0] : hold[7:0];
  assign bt_last   = !accept && (byte_idx == 3'd6);

  uart_byte_tx #(
    .BPS_CNT(BPS_CNT)
  ) u_byte_tx (
    .clk  (clk),
    .rst  (rst),
    .start(bt_start),
    .data (bt_data),
    .last (bt_last),
    .txd  (uart_txd),
    .done (bt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEQ_IDLE;
      hold          <= '0;
      byte_idx      <= '0;
      gap_cnt       <= '0;
      tx_done       <= 1'b0;
      busy          <= 1'b0;
      data_in_ready <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (accept) begin
            state         <= SEQ_BYTE;
            hold          <= {8'h00, data_64[63:8]};
            byte_idx      <= '0;
            busy          <= 1'b1;
            data_in_ready <= 1'b0;
          end
        end
        SEQ_BYTE: begin
          if (bt_done) begin
            if (byte_idx == 3'd7) begin
              state         <= SEQ_IDLE;
              byte_idx      <= '0;
              busy          <= 1'b0;
              data_in_ready <= 1'b1;
              tx_done       <= 1'b1;
            end else if (GAP_CYC == 0) begin
              byte_idx <= byte_idx + 1'b1;
              hold     <= {8'h00, hold[63:8]};
            end else begin
              state   <= SEQ_GAP;
              gap_cnt <= '0;
            end
          end
        end
        SEQ_GAP: begin
          if (gap_cnt == GAP_MAX) begin
            state    <= SEQ_BYTE;
            gap_cnt  <= '0;
            byte_idx <= byte_idx + 1'b1;
            hold     <= {8'h00, hold[63:8]};
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_64.sv
// tb/tb_uart_tx_64.sv - randomized self-checking bench for uart_tx_64
module tb_uart_tx_64;

  localparam int NU   = 3;
  localparam int BPS0 = 50_000_000 / 115_200;
  localparam int BPS1 = 1_000_000 / 60_000;

  int bps_of[NU] = '{BPS0, BPS1, BPS1};
  int gap_of[NU] = '{0, 0, 100};

  logic          clk = 1'b0;
  logic [NU-1:0] rst;
  logic [NU-1:0] valid;
  logic [NU-1:0] ready;
  logic [NU-1:0] txd;
  logic [NU-1:0] busy;
  logic [NU-1:0] done;
  logic [63:0]   din[NU];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_64 u0 (
    .clk(clk), .rst(rst[0]), .data_64(din[0]), .data_in_valid(valid[0]),
    .data_in_ready(ready[0]), .uart_txd(txd[0]), .busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_64 #(.CLK_FREQ(1_000_000), .UART_BPS(60_000), .GAP_CYC(0)) u1 (
    .clk(clk), .rst(rst[1]), .data_64(din[1]), .data_in_valid(valid[1]),
    .data_in_ready(ready[1]), .uart_txd(txd[1]), .busy(busy[1]), .tx_done(done[1])
  );

  uart_tx_64 #(.CLK_FREQ(1_000_000), .UART_BPS(60_000), .GAP_CYC(100)) u2 (
    .clk(clk), .rst(rst[2]), .data_64(din[2]), .data_in_valid(valid[2]),
    .data_in_ready(ready[2]), .uart_txd(txd[2]), .busy(busy[2]), .tx_done(done[2])
  );

  task automatic drive_accept(input int u, input logic [63:0] w);
    @(negedge clk);
    vectors++;
    if (ready[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept u%0d: got %b want 1", u, ready[u]);
    end
    din[u]   = w;
    valid[u] = 1'b1;
    @(posedge clk);
    #1 valid[u] = 1'b0;
  endtask

  task automatic check_idle(input int u, input int n, input string name);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if ({txd[u], busy[u], ready[u], done[u]} !== 4'b1010) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s idle: %0d of %0d cycles not txd=1 busy=0 ready=1 done=0", name, bad, n);
    end
  endtask

  task automatic check_word(input int u, input logic [63:0] w, input int poke_cyc,
                            input int abort_cyc, input bit chain, input logic [63:0] nxt,
                            input string name);
    bit          exp_q[$];
    logic        samp[$];
    logic [7:0]  b;
    logic [63:0] dec;
    int bps, gap, total, base;
    int n_bad_line, first_bad, n_done, done_at, n_bad_busy, frame_bad;
    bps = bps_of[u];
    gap = gap_of[u];
    n_bad_line = 0; first_bad = -1; n_done = 0; done_at = -1; n_bad_busy = 0; frame_bad = 0;
    dec = '0;
    for (int k = 0; k < 8; k++) begin
      b = w[8*k +: 8];
      repeat (bps) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (bps) exp_q.push_back(b[i]);
      repeat (bps) exp_q.push_back(1'b1);
      if (k < 7) repeat (gap) exp_q.push_back(1'b1);
    end
    total = exp_q.size();
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (c == abort_cyc) begin
        rst[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({txd[u], busy[u], ready[u], done[u]} !== 4'b1010) begin
          miscompares++;
          $display("FAIL %s after_reset: txd,busy,ready,done=%b want 1010",
                   name, {txd[u], busy[u], ready[u], done[u]});
        end
        rst[u] = 1'b0;
        return;
      end
      samp.push_back(txd[u]);
      if (txd[u] !== exp_q[c]) begin
        if (n_bad_line == 0) first_bad = c;
        n_bad_line++;
      end
      if (done[u] === 1'b1) begin
        if (n_done == 0) done_at = c;
        n_done++;
      end
      if ({busy[u], ready[u]} !== ((c == total - 1) ? 2'b01 : 2'b10)) n_bad_busy++;
      if (c == poke_cyc) begin
        din[u]   = 64'h0;
        valid[u] = 1'b1;
      end
      if (c == poke_cyc + 1) valid[u] = 1'b0;
      if (chain && c == total - 1) begin
        din[u]   = nxt;
        valid[u] = 1'b1;
      end
    end
    if (chain) begin
      @(posedge clk);
      #1 valid[u] = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      base = k * (10 * bps + gap);
      if (samp[base + bps/2] !== 1'b0 || samp[base + 9*bps + bps/2] !== 1'b1) frame_bad++;
      for (int i = 0; i < 8; i++) dec[8*k + i] = samp[base + (1 + i)*bps + bps/2];
    end
    vectors++;
    if (n_bad_line != 0) begin
      miscompares++;
      $display("FAIL %s line: %0d bad cycles, first at %0d, want 0 bad of %0d", name, n_bad_line, first_bad, total);
    end
    vectors++;
    if (n_done != 1 || done_at != total - 1) begin
      miscompares++;
      $display("FAIL %s tx_done: %0d pulses, first at cycle %0d, want 1 at cycle %0d", name, n_done, done_at, total - 1);
    end
    vectors++;
    if (n_bad_busy != 0) begin
      miscompares++;
      $display("FAIL %s busy_ready: %0d bad cycles, want 0", name, n_bad_busy);
    end
    vectors++;
    if (dec !== w) begin
      miscompares++;
      $display("FAIL %s decode: got %h want %h", name, dec, w);
    end
    vectors++;
    if (frame_bad != 0) begin
      miscompares++;
      $display("FAIL %s framing: %0d bytes with bad start/stop, want 0", name, frame_bad);
    end
  endtask

  task automatic test_reset();
    rst   = '1;
    valid = '0;
    for (int u = 0; u < NU; u++) din[u] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      vectors++;
      if ({txd[u], busy[u], ready[u], done[u]} !== 4'b1010) begin
        miscompares++;
        $display("FAIL reset u%0d: txd,busy,ready,done=%b want 1010", u, {txd[u], busy[u], ready[u], done[u]});
      end
    end
    rst = '0;
  endtask

  task automatic test_nominal();
    drive_accept(0, 64'h91EF9BE64104FB5D);
    check_word(0, 64'h91EF9BE64104FB5D, -1, -1, 1'b0, 64'h0, "nominal");
    check_idle(0, 5, "nominal");
  endtask

  task automatic test_random();
    logic [63:0] w;
    for (int n = 0; n < 4; n++) begin
      w = {$urandom(), $urandom()};
      drive_accept(1, w);
      check_word(1, w, -1, -1, 1'b0, 64'h0, "random");
      check_idle(1, 3, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    drive_accept(1, w);
    check_word(1, w, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "b2b_first");
    check_word(1, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, 1'b0, 64'h0, "b2b_second");
    check_idle(1, 5, "b2b");
  endtask

  task automatic test_busy_reject();
    drive_accept(1, 64'hA5A5_A5A5_A5A5_A5A5);
    check_word(1, 64'hA5A5_A5A5_A5A5_A5A5, 3*10*BPS1 + 5, -1, 1'b0, 64'h0, "busy_reject");
    check_idle(1, 10*BPS1, "busy_reject");
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    drive_accept(1, w);
    check_word(1, w, -1, 2*10*BPS1 + 4*BPS1 + BPS1/2, 1'b0, 64'h0, "reset_mid");
    check_idle(1, 30, "reset_mid");
    w = {$urandom(), $urandom()};
    drive_accept(1, w);
    check_word(1, w, -1, -1, 1'b0, 64'h0, "after_reset");
  endtask

  task automatic test_gap();
    drive_accept(2, 64'h0);
    check_word(2, 64'h0, -1, -1, 1'b0, 64'h0, "gap");
    check_idle(2, 5, "gap");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    test_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_64.md
# uart_tx_64

Transmits one 64-bit word as eight 8N1 UART frames, least-significant byte first. It is the loop-back/return stage of the course design: the 64-bit result produced alongside `top_out` (a UART receiver that assembles `data_64`) is sent back to the host over `uart_txd`. Bit timing and byte order match the receiver exactly, so a word sent by this block and received by `top_out` reproduces the original value.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `GAP_CYC`, default 0: extra idle-high cycles inserted after each stop bit, except after byte 7.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_64`, input, 64: word to send; sampled only on accept.
- `data_in_valid`, input, 1: request to send `data_64`.
- `data_in_ready`, output, 1: block can accept a word.
- `uart_txd`, output, 1: serial line; idles high.
- `busy`, output, 1: a word is in transmission.
- `tx_done`, output, 1: one-cycle pulse when the last stop bit of byte 7 ends.

## Operation
- Derived constant: BPS_CNT = CLK_FREQ / UART_BPS, using integer division. The default is 434 cycles per bit.
- Accept rule: a word is accepted on a rising edge where `data_in_valid` and `data_in_ready` are both 1. On accept, `data_64` is latched into a shift/hold register. Later changes on `data_64` have no effect.
- `data_in_valid` while `data_in_ready`=0 is ignored. It is not queued.
- State machine:
  - IDLE → START on accept.
  - START (txd=0, one bit period) → DATA.
  - DATA (8 bits, LSB first, one bit period each) → STOP.
  - STOP (txd=1, one bit period) → GAP if GAP_CYC>0 and byte<7.
  - STOP → START if GAP_CYC=0 and byte<7.
  - STOP → IDLE if byte=7.
  - GAP (txd=1, GAP_CYC cycles) → START.
- Byte order: byte k = data_64[8k+7:8k], for k=0..7.
- Counters:
  - Bit-period counter 0..BPS_CNT-1; clears on every state or bit change.
  - Bit index 0..7.
  - Byte index 0..7; wraps to 0 on return to IDLE.
- `busy` = (state != IDLE). `data_in_ready` = (state == IDLE).
- Reset mid-frame aborts the word immediately. The next cycle shows `uart_txd`=1, IDLE, and `tx_done`=0. No partial-word `tx_done` is produced.

## Timing
- Reset values: `uart_txd`=1, `busy`=0, `data_in_ready`=1, `tx_done`=0. All counters are 0.
- All outputs are registered. `uart_txd` has no combinational path from inputs.
- Accept at edge T:
  - `uart_txd` falls and `busy` rises from T+1.
  - `data_in_ready` falls from T+1.
- Every bit, including start and stop, holds exactly BPS_CNT cycles.
- Word duration, from the first start-bit cycle to the end of the last stop bit: 80·BPS_CNT + 7·GAP_CYC cycles. With defaults this is 34720 cycles.
- `tx_done` is high for exactly one cycle: the first IDLE cycle. `data_in_ready` is 1 in that same cycle.
- A valid in that `tx_done` cycle is accepted. The next start bit then follows the previous stop bit with zero idle cycles (back-to-back words).
- A simultaneous `rst` and `data_in_valid` results in reset, with no accept.

## Structure
- Shared package `uart_pkg` holds:
  - the default CLK_FREQ and UART_BPS, also used by `top_out`'s receiver;
  - the BPS_CNT function;
  - the state enum (IDLE, START, DATA, STOP, GAP).
- Natural sub-module: `uart_byte_tx`, an 8N1 single-byte serializer with start/done handshake.
  - `uart_tx_64` is the byte sequencer around it.
  - It owns the 64-bit hold register, the byte index, the GAP timer and `tx_done`.

## Test plan
- **Nominal word:** send 0x91EF9BE64104FB5D with defaults.
  - Decode `uart_txd` at bit centres: required bytes 5D, FB, 04, 41, E6, 9B, EF, 91.
  - Every start bit = 0, every stop bit = 1, each bit exactly 434 cycles.
  - `tx_done` pulses once, 34720 cycles after the first start-bit cycle.
- **Loop-back:** connect `uart_txd` to `top_out.uart_rxd` and send 0x0123456789ABCDEF.
  - `data_out_done` must fire with `data_64`=0x0123456789ABCDEF.
- **Back-to-back:** assert valid in the `tx_done` cycle with 0xFFFFFFFFFFFFFFFF.
  - The next start bit follows the stop bit with zero idle cycles.
  - The second `tx_done` comes 34720 cycles later.
- **Busy rejection:** pulse valid with 0x0 mid-transmission of 0xA5A5A5A5A5A5A5A5.
  - The line output is unchanged and only one `tx_done` is produced.
- **Reset mid-byte:** assert `rst` during the DATA bit 3 of byte 2.
  - Next cycle: `uart_txd`=1, `busy`=0, `data_in_ready`=1, no `tx_done`.
  - A new word is then sent correctly.
- **Gap:** with GAP_CYC=100, send 0x0000000000000000.
  - Each inter-byte idle is exactly 100 cycles high; there is none after byte 7.
  - Total duration is 35420 cycles.
